// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared constants, state encoding and helpers for the interrupt dispatcher
package intr_pkg;

  // Source indices; a lower index wins when several are pending.
  localparam logic [2:0] SRC_UART  = 3'd0;
  localparam logic [2:0] SRC_CLOCK = 3'd1;
  localparam logic [2:0] SRC_TIMER = 3'd2;
  localparam logic [2:0] SRC_SWI   = 3'd3;
  localparam logic [2:0] SRC_SD    = 3'd4;

  // Interrupt controller register map on the io bus.
  localparam logic [3:0] IO_PENDING = 4'd0;
  localparam logic [3:0] IO_STATUS  = 4'd1;
  localparam logic [3:0] IO_ENABLE  = 4'd2;
  localparam logic [3:0] IO_SET     = 4'd4;
  localparam logic [3:0] IO_CLEAR   = 4'd5;

  // Sources the dispatcher clears itself; uart and sd are level sources
  // that the handler clears at the peripheral.
  localparam logic [4:0] CLEARABLE = 5'b01110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_PRESENT,
    ST_SERVICE,
    ST_CLEAR
  } state_t;

  function automatic logic is_clearable(input logic [2:0] idx);
    return (idx <= SRC_SD) && CLEARABLE[idx];
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// rtl/intr_prio_enc.sv - fixed-priority encoder, lowest set bit wins
module intr_prio_enc
  import intr_pkg::*;
(
  input  logic [4:0] req,
  output logic       valid,
  output logic [2:0] idx
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/intr_dispatch.sv
// rtl/intr_dispatch.sv - CPU-side interrupt dispatcher: read pending, present vector, clear source
module intr_dispatch
  import intr_pkg::*;
#(
  parameter logic [15:0] VEC_BASE   = 16'h0010,
  parameter int          VEC_STRIDE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        interrupt,
  input  logic        cpu_irq_en,
  output logic        cpu_irq_req,
  output logic [15:0] cpu_irq_vec,
  input  logic        cpu_irq_ack,
  input  logic        cpu_irq_done,
  output logic        io_req,
  output logic        io_write,
  output logic [3:0]  io_addr,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  input  logic        io_gnt,
  output logic        busy,
  output logic [7:0]  spurious_count
);

  state_t      state, state_nx;
  logic [2:0]  idx_q;
  logic [15:0] vec_q;
  logic [7:0]  spur_q;
  logic        capture;
  logic        spur_inc;
  logic        enc_valid;
  logic [2:0]  enc_idx;
  logic [15:0] vec_nx;
  logic        unused_rdata;

  // Only the five source bits of the pending register carry meaning.
  assign unused_rdata = ^io_rdata[15:5];

  intr_prio_enc u_prio_enc (
    .req   (io_rdata[4:0]),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  assign vec_nx = VEC_BASE + 16'(VEC_STRIDE) * {13'd0, enc_idx};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Captured source/vector and the saturating spurious counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= 3'd0;
      vec_q  <= 16'd0;
      spur_q <= 8'd0;
    end else begin
      if (capture) begin
        idx_q <= enc_idx;
        vec_q <= vec_nx;
      end
      if (spur_inc && spur_q != 8'hFF) spur_q <= spur_q + 8'd1;
    end
  end

  // Next state and io bus drive; io fields stay zero unless a request is up.
  always_comb begin
    state_nx = state;
    io_req   = 1'b0;
    io_write = 1'b0;
    io_addr  = 4'd0;
    io_wdata = 16'd0;
    capture  = 1'b0;
    spur_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (interrupt && cpu_irq_en) state_nx = ST_READ;
      end
      ST_READ: begin
        io_req  = 1'b1;
        io_addr = IO_PENDING;
        if (io_gnt) begin
          if (enc_valid) begin
            capture  = 1'b1;
            state_nx = ST_PRESENT;
          end else begin
            spur_inc = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      ST_PRESENT: begin
        // Ack takes precedence over a simultaneous enable drop.
        if (cpu_irq_ack)     state_nx = ST_SERVICE;
        else if (!cpu_irq_en) state_nx = ST_IDLE;
      end
      ST_SERVICE: begin
        if (cpu_irq_done) state_nx = is_clearable(idx_q) ? ST_CLEAR : ST_IDLE;
      end
      ST_CLEAR: begin
        io_req   = 1'b1;
        io_write = 1'b1;
        io_addr  = IO_CLEAR;
        io_wdata = 16'd1 << idx_q;
        if (io_gnt) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign cpu_irq_req    = (state == ST_PRESENT);
  assign cpu_irq_vec    = vec_q;
  assign busy           = (state != ST_IDLE);
  assign spurious_count = spur_q;

endmodule

// File: doc/intr_dispatch.md
# intr_dispatch

CPU-side interrupt dispatcher: the initiator at the other end of the interrupt controller's `interrupt` line and io register port. When `interrupt` rises and the CPU has interrupts enabled, it reads the controller's pending register over the io bus and picks the highest-priority source. It then presents a vector to the CPU with a req/ack handshake, waits for end-of-handler, and writes the controller's clear register for software-clearable sources. It sits between the interrupt controller and the CPU core, sharing the io bus through a grant.

## Interface
- `VEC_BASE`, default 16'h0010: vector of source 0.
- `VEC_STRIDE`, default 4: vector spacing per source index.
- `clk` in 1: single clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `interrupt` in 1: level from the interrupt controller (OR of pending).
- `cpu_irq_en` in 1: CPU global interrupt enable.
- `cpu_irq_req` out 1: vector valid, request to the CPU.
- `cpu_irq_vec` out 16: `VEC_BASE + idx*VEC_STRIDE`, valid while `cpu_irq_req` is high.
- `cpu_irq_ack` in 1: CPU accepts the vector.
- `cpu_irq_done` in 1: one-cycle pulse at end of handler.
- `io_req` out 1: io bus access request.
- `io_write` out 1: 1 = write, 0 = read.
- `io_addr` out 4: controller register address.
- `io_wdata` out 16: write data.
- `io_rdata` in 16: read data, combinational, valid in the `io_gnt` cycle.
- `io_gnt` in 1: bus granted this cycle; the access completes at that edge.
- `busy` out 1: state is not IDLE.
- `spurious_count` out 8: saturating count of empty pending reads.

## Operation
- Source index: 0 uart, 1 clock, 2 timer, 3 swi, 4 sd. Lower index has higher priority.
- Clearable mask is 5'b01110 (clock, timer, swi). Uart and sd are level sources, cleared at the source by the handler.
- States:
  - IDLE: go to READ if `interrupt && cpu_irq_en`.
  - READ: drive `io_req`=1, `io_write`=0, `io_addr`=0. On `io_gnt`, priority-encode `io_rdata[4:0]`.
    - If nonzero: register idx and vec, go to PRESENT.
    - If zero: increment `spurious_count` (saturates at 255), go to IDLE.
  - PRESENT: drive `cpu_irq_req`=1. On `cpu_irq_ack`, go to SERVICE. If `cpu_irq_en` drops before ack, withdraw the request and go to IDLE. If ack and enable-drop occur in the same cycle, ack wins.
  - SERVICE: wait for `cpu_irq_done`. If idx is clearable, go to CLEAR; otherwise go to IDLE.
  - CLEAR: drive `io_req`=1, `io_write`=1, `io_addr`=5, `io_wdata`=16'h1<<idx. On `io_gnt`, go to IDLE.
- `cpu_irq_done` or `cpu_irq_ack` outside its own state is ignored.
- `io_rdata[15:5]` is ignored. `io_rdata` is only sampled on `io_gnt` in READ.
- When `io_req` is low, `io_write`, `io_addr` and `io_wdata` drive 0.

## Timing
- Reset (asynchronous on `reset_n` low) drives immediately: state IDLE, `cpu_irq_req`=0, `cpu_irq_vec`=0, `io_req`=0, `io_write`=0, `io_addr`=0, `io_wdata`=0, `busy`=0, `spurious_count`=0. Reset mid-transaction abandons it; no clear write is issued.
- Latency, with `io_gnt` tied high: `interrupt` sampled high at edge 0 → `io_req` high in cycle 1 → `cpu_irq_req` high in cycle 2.
- Withheld `io_gnt`: `io_req`, `io_write`, `io_addr` and `io_wdata` hold stable until the grant edge. There is no timeout.
- `cpu_irq_req` and `cpu_irq_vec` are registered and stable from assertion through the ack edge.
- IDLE always lasts at least one cycle after CLEAR or SERVICE. This lets the controller's cleared status propagate before `interrupt` is re-sampled.
- `cpu_irq_done` is accepted in the first SERVICE cycle; CLEAR `io_req` is asserted the next cycle.

## Structure
- Package `intr_pkg`:
  - Source index constants.
  - io address constants: PENDING=0, STATUS=1, ENABLE=2, SET=4, CLEAR=5.
  - CLEARABLE mask = 5'b01110.
  - State enum: IDLE, READ, PRESENT, SERVICE, CLEAR.
- Sub-module `intr_prio_enc`: 5-bit input, outputs `valid` and a 3-bit `idx`. It is combinational and instantiated once in READ's capture path.

## Test plan
- Reset: hold `reset_n` low with `interrupt`=1 → all outputs 0; after release, READ begins 1 cycle later.
- Timer: `io_rdata`=16'h0004, `io_gnt`=1 → `cpu_irq_vec`=16'h0018; ack then done → write `io_addr`=5, `io_wdata`=16'h0004, then IDLE.
- Priority: `io_rdata`=16'h0016 → `cpu_irq_vec`=16'h0014 (clock), clear write 16'h0002. Repeat with `io_rdata`=16'h0011 → `cpu_irq_vec`=16'h0010; after done, no io write (uart not clearable).
- Spurious: 256 grant cycles in READ with `io_rdata`=0 → `cpu_irq_req` never asserts; `spurious_count` reaches 255 and stays there.
- Grant stall and enable drop: withhold `io_gnt` 3 cycles in CLEAR → `io_addr`/`io_wdata` stable throughout. Drop `cpu_irq_en` in PRESENT without ack → `cpu_irq_req` falls next cycle, state IDLE.
- Reset mid-SERVICE: assert `reset_n` low → `busy` low immediately; no CLEAR write follows the release of reset.
